sram_bus_responder: RTL and testbench
=====================================

# sram_bus_responder

Bus-slave (responder) end of the shared burst bus. It sits in front of a 512×32 on-chip SRAM and serves the single-word and burst read/write transactions that bus initiators such as the DMA controller issue. The block decodes the start address and checks the burst against the window. It then streams SRAM words onto the bus for reads, or commits incoming bus words into SRAM for writes. It terminates read bursts with end-of-transaction and reports protocol or range faults with a one-cycle error pulse.

## Interface
- BASE_ADDRESS, 32'h4000_0000, byte address of SRAM word 0 on the bus; window is BASE_ADDRESS .. BASE_ADDRESS+2047.
- clock  in  1  system clock; everything is rising-edge.
- reset  in  1  synchronous, active-high reset.
- busIn_address_data  in  32  address in the begin cycle; write data afterwards.
- busIn_begin_transaction  in  1  initiator starts a transaction this cycle.
- busIn_read_n_write  in  1  1 = read, 0 = write; sampled with begin.
- busIn_burst_size  in  8  number of words minus 1; sampled with begin.
- busIn_data_valid  in  1  write data word present.
- busIn_end_transaction  in  1  initiator ends a write or aborts a read.
- busIn_error  in  1  initiator abort.
- busOut_address_data  out  32  read data.
- busOut_data_valid  out  1  read data word present.
- busOut_end_transaction  out  1  read burst complete.
- busOut_busy  out  1  driven constant 0; the responder never stalls.
- busOut_error  out  1  one-cycle fault pulse.
- SRAM_write_enable  out  1  combinational write strobe.
- SRAM_address  out  9  combinational word address.
- SRAM_data  out  32  combinational write data, equal to busIn_address_data.
- SRAM_result  in  32  SRAM read data, valid one cycle after the address is presented.

## Operation
- States: IDLE, WRITE_BURST, READ_WAIT, READ_BURST, READ_END, ERROR. Registers: index (9 bit), count (8 bit), last (8 bit, latched burst_size).
- Decode in IDLE with begin=1:
  - offset = addr − BASE_ADDRESS, computed in 32 bits.
  - The address hits when addr ≥ BASE_ADDRESS and offset < 2048. Non-hits are ignored and the state stays IDLE.
  - A hit is valid when offset[1:0]=0 and (offset>>2)+burst_size ≤ 511, evaluated with 10-bit math.
  - A hit that fails the valid check → ERROR.
- Valid hit: index←offset[10:2], count←0, last←burst_size. Read → READ_WAIT; write → WRITE_BURST.
- READ_WAIT: SRAM_address=index. At the edge, index←index+1 and the state moves to READ_BURST.
- READ_BURST: busOut_data_valid=1 and busOut_address_data=SRAM_result; SRAM_address=index.
  - Each edge: index+1, count+1.
  - When count==last at the edge → READ_END.
- READ_END: busOut_end_transaction=1 for one cycle, then → IDLE.
- WRITE_BURST: SRAM_address=index and SRAM_write_enable=busIn_data_valid.
  - Each valid word: index+1, count+1.
  - busIn_end_transaction → IDLE. A short burst is legal and the words already written stay.
  - A valid word arriving after last+1 words have been accepted → ERROR. That word is not written (write enable forced 0).
- ERROR: busOut_error=1 for one cycle, then → IDLE.
- Priority (highest first): reset, busIn_error, busIn_end_transaction, normal flow.
  - busIn_error in any non-IDLE state → IDLE next cycle, with no error pulse and no further writes. A write present in the same cycle as the error is suppressed.
  - busIn_end_transaction during READ_WAIT or READ_BURST → IDLE with no busOut_end_transaction.
  - busIn_begin_transaction outside IDLE is ignored.
- Outside READ_BURST, busOut_address_data=0.

## Timing
- Reset: state IDLE and index/count/last=0.
  - All bus outputs are 0.
  - SRAM_write_enable is gated by reset combinationally, so it is 0 in the reset cycle itself.
  - Reset mid-burst drops the burst with no end or error pulse.
- Read latency: begin in cycle 0, READ_WAIT in cycle 1, first data in cycle 2. Words then arrive back to back, one per cycle.
- For burst_size=N, data is valid in cycles 2..N+2 and busOut_end_transaction is high in cycle N+3.
- Write: a word on busIn_data_valid in cycle k is committed at the edge ending cycle k, with zero added latency. The first word may arrive in cycle 1.
- Range/alignment error: busOut_error is high in cycle 1, and the responder accepts a new begin from cycle 2.
- Back-to-back transactions: a new begin is accepted in the first cycle the state is IDLE.

## Test plan
- Read burst: preload SRAM[5..8]=0xA0..0xA3, then begin read at BASE+20 with burst 3. Required: data 0xA0,0xA1,0xA2,0xA3 in cycles 2–5, end_transaction in cycle 6, then IDLE.
- Write burst: begin write at BASE+0 with burst 2, then send 0x11,0x22,0x33 and end. Required: SRAM[0..2]=0x11,0x22,0x33, and no busOut activity.
- Faults:
  - Address BASE+2044 with burst 1 → busOut_error in cycle 1.
  - Address BASE+2 → busOut_error in cycle 1.
  - Address 0x1000_0000 → no response, with all outputs staying 0.
- Write overflow: burst 0 followed by two data words. Required: the first word is written, the second raises error and SRAM[index+1] is unchanged.
- Aborts:
  - busIn_error in the 2nd read data cycle → no end_transaction, and the state is IDLE next cycle.
  - reset mid-write → the remaining words are not written.
- Single word and wrap edge: read at BASE+2044 with burst 0. Required: one data word from SRAM[511] in cycle 2, end_transaction in cycle 3.

Source files
------------

// File: rtl/sram_bus_responder.sv
// Bus-side responder for a 512x32 on-chip SRAM.
// Decodes a transaction start address against the SRAM window, then streams
// read words from the SRAM onto the bus or commits incoming bus words into
// the SRAM. Read bursts finish with an end-of-transaction pulse. Range,
// alignment and write-overrun faults produce a one-cycle error pulse.
// The SRAM itself lives outside this block: it has a registered read port,
// so read data appears one cycle after the address is presented.
module sram_bus_responder #(
  parameter logic [31:0] BASE_ADDRESS = 32'h4000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] busIn_address_data,
  input  logic        busIn_begin_transaction,
  input  logic        busIn_read_n_write,
  input  logic [7:0]  busIn_burst_size,
  input  logic        busIn_data_valid,
  input  logic        busIn_end_transaction,
  input  logic        busIn_error,
  output logic [31:0] busOut_address_data,
  output logic        busOut_data_valid,
  output logic        busOut_end_transaction,
  output logic        busOut_busy,
  output logic        busOut_error,
  output logic        SRAM_write_enable,
  output logic [8:0]  SRAM_address,
  output logic [31:0] SRAM_data,
  input  logic [31:0] SRAM_result
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WRITE_BURST = 3'd1,
    READ_WAIT   = 3'd2,
    READ_BURST  = 3'd3,
    READ_END    = 3'd4,
    ERROR       = 3'd5
  } state_t;

  // Window is 2 KiB: 512 words of 4 bytes.
  localparam logic [31:0] WINDOW_BYTES = 32'd2048;
  localparam logic [9:0]  LAST_WORD    = 10'd511;

  state_t      state_reg, state_next;
  logic [8:0]  index_reg, index_next;
  logic [7:0]  count_reg, count_next;
  logic [7:0]  last_reg,  last_next;
  // Set once last+1 words have been written; count alone cannot express
  // 256 accepted words in 8 bits, so overrun detection uses this flag.
  logic        full_reg,  full_next;

  logic        data_valid_reg;
  logic        end_reg;
  logic        error_reg;

  logic [31:0] offset;
  logic        addr_hit;
  logic [9:0]  span_end;
  logic        req_valid;
  logic        write_state;
  logic        word_commit;
  logic        write_overrun;

  // Start-address decode: window hit, then alignment and burst fit.
  always_comb begin
    offset    = busIn_address_data - BASE_ADDRESS;
    addr_hit  = (busIn_address_data >= BASE_ADDRESS) && (offset < WINDOW_BYTES);
    span_end  = {1'b0, offset[10:2]} + {2'b00, busIn_burst_size};
    req_valid = (offset[1:0] == 2'b00) && (span_end <= LAST_WORD);
  end

  // Write-path qualification: an abort kills the word in the same cycle,
  // and a word beyond the latched burst length is never committed.
  always_comb begin
    write_state   = (state_reg == WRITE_BURST);
    word_commit   = write_state && busIn_data_valid && !busIn_error && !full_reg;
    write_overrun = write_state && busIn_data_valid && !busIn_error && full_reg;
  end

  // Next-state and datapath update; abort outranks end, which outranks flow.
  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    count_next = count_reg;
    last_next  = last_reg;
    full_next  = full_reg;
    case (state_reg)
      IDLE: begin
        if (busIn_begin_transaction && addr_hit) begin
          if (req_valid) begin
            index_next = offset[10:2];
            count_next = 8'd0;
            last_next  = busIn_burst_size;
            full_next  = 1'b0;
            state_next = busIn_read_n_write ? READ_WAIT : WRITE_BURST;
          end else begin
            state_next = ERROR;
          end
        end
      end
      WRITE_BURST: begin
        if (word_commit) begin
          index_next = index_reg + 9'd1;
          count_next = count_reg + 8'd1;
          if (count_reg == last_reg) begin
            full_next = 1'b1;
          end
        end
        if (busIn_error || busIn_end_transaction) begin
          state_next = IDLE;
        end else if (write_overrun) begin
          state_next = ERROR;
        end
      end
      READ_WAIT: begin
        if (busIn_error || busIn_end_transaction) begin
          state_next = IDLE;
        end else begin
          index_next = index_reg + 9'd1;
          state_next = READ_BURST;
        end
      end
      READ_BURST: begin
        if (busIn_error || busIn_end_transaction) begin
          state_next = IDLE;
        end else begin
          index_next = index_reg + 9'd1;
          count_next = count_reg + 8'd1;
          if (count_reg == last_reg) begin
            state_next = READ_END;
          end
        end
      end
      READ_END: state_next = IDLE;
      ERROR:    state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // State, datapath registers and registered bus status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      index_reg      <= 9'd0;
      count_reg      <= 8'd0;
      last_reg       <= 8'd0;
      full_reg       <= 1'b0;
      data_valid_reg <= 1'b0;
      end_reg        <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      index_reg      <= index_next;
      count_reg      <= count_next;
      last_reg       <= last_next;
      full_reg       <= full_next;
      data_valid_reg <= (state_next == READ_BURST);
      end_reg        <= (state_next == READ_END);
      error_reg      <= (state_next == ERROR);
    end
  end

  // Bus and SRAM port drive; read data passes straight from the SRAM port.
  always_comb begin
    busOut_data_valid      = data_valid_reg;
    busOut_address_data    = data_valid_reg ? SRAM_result : 32'd0;
    busOut_end_transaction = end_reg;
    busOut_error           = error_reg;
    busOut_busy            = 1'b0;
    SRAM_address           = index_reg;
    SRAM_data              = busIn_address_data;
    SRAM_write_enable      = word_commit && !reset;
  end

endmodule

// File: tb/tb_sram_bus_responder.sv
// Directed bench for sram_bus_responder with a behavioural SRAM model.
// Expected read words are queued when a read begins and popped as the
// responder presents data.
module tb_sram_bus_responder;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] busIn_address_data = '0;
  logic        busIn_begin_transaction = 1'b0;
  logic        busIn_read_n_write = 1'b0;
  logic [7:0]  busIn_burst_size = '0;
  logic        busIn_data_valid = 1'b0;
  logic        busIn_end_transaction = 1'b0;
  logic        busIn_error = 1'b0;
  logic [31:0] busOut_address_data;
  logic        busOut_data_valid;
  logic        busOut_end_transaction;
  logic        busOut_busy;
  logic        busOut_error;
  logic        SRAM_write_enable;
  logic [8:0]  SRAM_address;
  logic [31:0] SRAM_data;
  logic [31:0] SRAM_result;

  // SRAM model with a preload port used only while the responder is idle.
  logic [31:0] mem [0:511];
  logic        pl_en = 1'b0;
  logic [8:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (SRAM_write_enable) mem[SRAM_address] <= SRAM_data;
    SRAM_result <= mem[SRAM_address];
  end

  sram_bus_responder dut (
    .clock                   (clock),
    .reset                   (reset),
    .busIn_address_data      (busIn_address_data),
    .busIn_begin_transaction (busIn_begin_transaction),
    .busIn_read_n_write      (busIn_read_n_write),
    .busIn_burst_size        (busIn_burst_size),
    .busIn_data_valid        (busIn_data_valid),
    .busIn_end_transaction   (busIn_end_transaction),
    .busIn_error             (busIn_error),
    .busOut_address_data     (busOut_address_data),
    .busOut_data_valid       (busOut_data_valid),
    .busOut_end_transaction  (busOut_end_transaction),
    .busOut_busy             (busOut_busy),
    .busOut_error            (busOut_error),
    .SRAM_write_enable       (SRAM_write_enable),
    .SRAM_address            (SRAM_address),
    .SRAM_data               (SRAM_data),
    .SRAM_result             (SRAM_result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    busIn_address_data      = '0;
    busIn_begin_transaction = 1'b0;
    busIn_read_n_write      = 1'b0;
    busIn_burst_size        = '0;
    busIn_data_valid        = 1'b0;
    busIn_end_transaction   = 1'b0;
    busIn_error             = 1'b0;
  endtask

  task automatic drive_begin(input logic [31:0] addr, input logic rnw, input logic [7:0] burst);
    clear_inputs();
    busIn_address_data      = addr;
    busIn_begin_transaction = 1'b1;
    busIn_read_n_write      = rnw;
    busIn_burst_size        = burst;
  endtask

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    tick();
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_valid"}, {31'd0, busOut_data_valid}, 32'd0);
    chk({tag, "_end"},   {31'd0, busOut_end_transaction}, 32'd0);
    chk({tag, "_err"},   {31'd0, busOut_error}, 32'd0);
    chk({tag, "_data"},  busOut_address_data, 32'd0);
    chk({tag, "_busy"},  {31'd0, busOut_busy}, 32'd0);
  endtask

  // Read transaction; abort_cyc > 0 raises busIn_error in that cycle.
  task automatic run_read(input logic [31:0] addr, input logic [7:0] burst, input int abort_cyc);
    int n;
    bit aborted, exp_valid, exp_end;
    n = int'(burst);
    $display("txn read addr=%h burst=%0d abort_cycle=%0d", addr, burst, abort_cyc);
    tick();
    drive_begin(addr, 1'b1, burst);
    @(negedge clock);
    chk("rd_c0_valid", {31'd0, busOut_data_valid}, 32'd0);
    for (int c = 1; c <= n + 4; c++) begin
      tick();
      clear_inputs();
      if (c == abort_cyc) busIn_error = 1'b1;
      @(negedge clock);
      aborted   = (abort_cyc != 0) && (c > abort_cyc);
      exp_valid = !aborted && (c >= 2) && (c <= n + 2);
      exp_end   = !aborted && (c == n + 3);
      chk($sformatf("rd_c%0d_valid", c), {31'd0, busOut_data_valid}, {31'd0, exp_valid});
      chk($sformatf("rd_c%0d_end", c), {31'd0, busOut_end_transaction}, {31'd0, exp_end});
      chk($sformatf("rd_c%0d_err", c), {31'd0, busOut_error}, 32'd0);
      if (exp_valid && exp_q.size() != 0)
        chk($sformatf("rd_c%0d_data", c), busOut_address_data, exp_q.pop_front());
      else if (!exp_valid)
        chk($sformatf("rd_c%0d_data", c), busOut_address_data, 32'd0);
    end
    chk("rd_queue_drained", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // Begin that must either fault in cycle 1 or be ignored entirely.
  task automatic run_fault(input string tag, input logic [31:0] addr, input logic [7:0] burst,
                           input logic exp_err);
    $display("txn fault-probe %s addr=%h burst=%0d", tag, addr, burst);
    tick();
    drive_begin(addr, 1'b1, burst);
    @(negedge clock);
    check_quiet({tag, "_c0"});
    tick();
    clear_inputs();
    @(negedge clock);
    chk({tag, "_c1_err"}, {31'd0, busOut_error}, {31'd0, exp_err});
    chk({tag, "_c1_valid"}, {31'd0, busOut_data_valid}, 32'd0);
    chk({tag, "_c1_we"}, {31'd0, SRAM_write_enable}, 32'd0);
  endtask

  initial begin
    // Reset state
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    @(negedge clock);
    check_quiet("reset");
    chk("reset_we", {31'd0, SRAM_write_enable}, 32'd0);
    chk("reset_addr", {23'd0, SRAM_address}, 32'd0);
    preload(9'd5,   32'hA0);
    preload(9'd6,   32'hA1);
    preload(9'd7,   32'hA2);
    preload(9'd8,   32'hA3);
    preload(9'd10,  32'h0);
    preload(9'd11,  32'h5555_5555);
    preload(9'd15,  32'h0);
    preload(9'd16,  32'h0);
    preload(9'd17,  32'h0);
    preload(9'd511, 32'hDEAD_BEEF);
    tick();
    reset = 1'b0;

    // Read burst of four words
    exp_q.push_back(32'hA0); exp_q.push_back(32'hA1);
    exp_q.push_back(32'hA2); exp_q.push_back(32'hA3);
    run_read(BASE + 32'd20, 8'd3, 0);

    // Write burst of three words, end in a separate cycle
    $display("txn write addr=%h burst=2 words=3", BASE);
    tick();
    drive_begin(BASE, 1'b0, 8'd2);
    @(negedge clock);
    check_quiet("wr_c0");
    for (int i = 0; i < 3; i++) begin
      tick();
      clear_inputs();
      busIn_data_valid = 1'b1;
      busIn_address_data = 32'h11 * (i + 1);
      @(negedge clock);
      chk($sformatf("wr_w%0d_we", i), {31'd0, SRAM_write_enable}, 32'd1);
      chk($sformatf("wr_w%0d_addr", i), {23'd0, SRAM_address}, i);
      check_quiet($sformatf("wr_w%0d", i));
    end
    tick();
    clear_inputs();
    busIn_end_transaction = 1'b1;
    @(negedge clock);
    chk("wr_end_we", {31'd0, SRAM_write_enable}, 32'd0);
    check_quiet("wr_end");
    tick();
    clear_inputs();
    @(negedge clock);
    check_quiet("wr_after");
    chk("wr_mem0", mem[0], 32'h11);
    chk("wr_mem1", mem[1], 32'h22);
    chk("wr_mem2", mem[2], 32'h33);

    // Range, alignment and miss probes
    run_fault("range", BASE + 32'd2044, 8'd1, 1'b1);
    run_fault("misalign", BASE + 32'd2, 8'd0, 1'b1);
    // New begin accepted in cycle 2 after the fault pulse
    exp_q.push_back(32'hA0);
    run_read(BASE + 32'd20, 8'd0, 0);
    run_fault("miss_low", 32'h1000_0000, 8'd0, 1'b0);
    run_fault("miss_high", BASE + 32'd2048, 8'd0, 1'b0);

    // Write overrun: burst 0 then two words
    $display("txn write-overrun addr=%h burst=0 words=2", BASE + 32'd40);
    tick();
    drive_begin(BASE + 32'd40, 1'b0, 8'd0);
    tick();
    clear_inputs();
    busIn_data_valid = 1'b1;
    busIn_address_data = 32'hAAAA_0001;
    @(negedge clock);
    chk("ovf_w0_we", {31'd0, SRAM_write_enable}, 32'd1);
    tick();
    busIn_address_data = 32'hAAAA_0002;
    @(negedge clock);
    chk("ovf_w1_we", {31'd0, SRAM_write_enable}, 32'd0);
    chk("ovf_w1_err", {31'd0, busOut_error}, 32'd0);
    tick();
    clear_inputs();
    @(negedge clock);
    chk("ovf_err_pulse", {31'd0, busOut_error}, 32'd1);
    tick();
    @(negedge clock);
    chk("ovf_err_clear", {31'd0, busOut_error}, 32'd0);
    chk("ovf_mem10", mem[10], 32'hAAAA_0001);
    chk("ovf_mem11", mem[11], 32'h5555_5555);

    // Abort in the second read data cycle
    exp_q.push_back(32'hA0); exp_q.push_back(32'hA1);
    run_read(BASE + 32'd20, 8'd3, 3);

    // Reset in the middle of a write burst
    $display("txn write-reset addr=%h burst=3", BASE + 32'd60);
    tick();
    drive_begin(BASE + 32'd60, 1'b0, 8'd3);
    tick();
    clear_inputs();
    busIn_data_valid = 1'b1;
    busIn_address_data = 32'h77;
    tick();
    reset = 1'b1;
    busIn_address_data = 32'h88;
    @(negedge clock);
    chk("rst_we_gated", {31'd0, SRAM_write_enable}, 32'd0);
    tick();
    reset = 1'b0;
    busIn_address_data = 32'h99;
    @(negedge clock);
    chk("rst_idle_we", {31'd0, SRAM_write_enable}, 32'd0);
    check_quiet("rst_after");
    tick();
    clear_inputs();
    @(negedge clock);
    chk("rst_mem15", mem[15], 32'h77);
    chk("rst_mem16", mem[16], 32'h0);
    chk("rst_mem17", mem[17], 32'h0);

    // Single word at the last SRAM location
    exp_q.push_back(32'hDEAD_BEEF);
    run_read(BASE + 32'd2044, 8'd0, 0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
